muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the five-stage MIPS pipeline. It sits in the execute stage, directly downstream of the D→E pipeline register. It takes the forwarded rs/rt operands and a decoded operation from the execute-stage instruction. It drives the `Busy` indication that the hazard logic folds into `stall_E`, freezing the D/E registers while an operation is in flight.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

- `Clk`  in  1  clock; all state updates on rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  operation valid this cycle. Qualifies `Op`.
- `Op`  in  3  encoding:
  - 0 none
  - 1 MULT
  - 2 MULTU
  - 3 DIV
  - 4 DIVU
  - 5 MTHI
  - 6 MTLO
  - 7 reserved, treated as none
- `A`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- `B`  in  32  rt operand (divisor / multiplier).
- `Busy`  out  1  operation in flight. Registered, no combinational path from inputs.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- Reset (`Rst_n` low, any time, including mid-operation):
  - `HI`=0, `LO`=0, `Busy`=0, cycle counter=0, staging registers=0.
  - In-flight result is discarded.
- Idle, `Start`=1, `Op` in 1..4:
  - Operands are latched.
  - The result is computed into 64-bit staging (`{hi,lo}`).
  - The counter is loaded with `MUL_CYCLES` or `DIV_CYCLES`.
  - `Busy` goes to 1.
- MULT: signed 32×32→64. MULTU: unsigned. Result `HI`=product[63:32], `LO`=product[31:0].
- DIV: signed, quotient truncates toward zero, remainder takes the sign of the dividend. `LO`=quotient, `HI`=remainder.
- DIVU: unsigned.
- DIV with 0x80000000 / 0xFFFFFFFF: `LO`=0x80000000, `HI`=0.
- DIV/DIVU with `B`=0:
  - `HI`/`LO` are left unchanged at completion.
  - `Busy` still asserts for `DIV_CYCLES`.
- Busy state:
  - The counter decrements each cycle.
  - On the edge where the counter goes 1→0, `HI`/`LO` load the staging value and `Busy` drops to 0.
  - `HI`/`LO` hold their old values throughout the busy window.
- MTHI/MTLO with `Start`=1 while idle: `HI` (resp. `LO`) loads `A` at the next edge. No busy cycles.
- `Start`=1 while `Busy`=1 (any `Op`): ignored entirely. The hazard logic must never issue this; the bench flags it as an assertion.
- `Start`=1 with `Op` 0 or 7: no effect.
- `Start`=0: `Op`, `A`, `B` are don't-care.

## Timing
- `Start` sampled at edge k (Op 1..4):
  - `Busy`=1 from after edge k through edge k+N.
  - N=`MUL_CYCLES` or `DIV_CYCLES`.
- New `HI`/`LO` are visible after edge k+N, the same edge `Busy` falls.
- The instruction issuing `Start` is itself not stalled. The hazard logic stalls a following MFHI/MFLO/mult/div while `Busy` is 1, or in the issue cycle via `Start`.
- Back-to-back: a new `Start` is accepted at edge k+N+1 at the earliest, i.e. the first cycle `Busy` reads 0.
- MTHI/MTLO at edge k: value visible after edge k. Zero busy cycles.
- Counter width is ceil(log2(max(MUL_CYCLES,DIV_CYCLES)+1)). Both parameters must be ≥1.
- Async reset asserted mid-operation clears outputs immediately, without waiting for `Clk`.

## Test plan
- Reset, then MULT `A`=0xFFFFFFFE (-2), `B`=0x00000003 → `Busy` high exactly 5 cycles, then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFA. MULTU on the same operands → `HI`=0x00000002, `LO`=0xFFFFFFFA.
- DIV `A`=0xFFFFFFF9 (-7), `B`=2 → after 10 busy cycles `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF. DIVU 7/2 → `LO`=3, `HI`=1.
- MTHI 0x12345678, then DIV by `B`=0 → `Busy` 10 cycles, `HI` stays 0x12345678. DIV 0x80000000/0xFFFFFFFF → `LO`=0x80000000, `HI`=0.
- `HI`/`LO` stability: during a MULT busy window, `HI`/`LO` hold their prior values every cycle. `Start`/MTLO pulsed mid-busy → ignored, `LO` unchanged, completion result correct.
- Back-to-back: MULT completes, `Start` DIVU in the first non-busy cycle → accepted, `Busy` re-asserts for 10 cycles with no gap cycle lost.
- Assert `Rst_n`=0 at busy cycle 3 of a DIV → `Busy`, `HI`, `LO` go to 0 asynchronously. After release, no stale result ever lands in `HI`/`LO`.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers. The result is computed once when an operation starts and
// parked in staging registers. It is committed to HI/LO on the edge that
// ends the busy window.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      stage_hi, stage_lo;
  logic             stage_wr;      // clear when a divide by zero must leave HI/LO alone
  logic [31:0]      hi_r, lo_r;

  op_e              op;
  logic             accept;        // start of a multi-cycle operation
  logic             commit;        // last busy edge: staging -> HI/LO
  logic             wr_mthi, wr_mtlo;

  logic [63:0]      res_nxt;       // {hi, lo} computed from the current operands
  logic             res_wr_nxt;
  logic [CNT_W-1:0] cnt_load;
  logic [31:0]      div_b;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      quot_s, rem_s;

  assign op = op_e'(Op);

  // Result datapath: products, quotients and remainders for the operation being issued.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned, which would infer a latch.
    res_nxt    = 64'd0;
    res_wr_nxt = 1'b1;
    cnt_load   = CNT_W'(MUL_CYCLES);
    // A zero divisor is replaced by one so the divider never produces X;
    // the result is then discarded through res_wr_nxt.
    div_b      = (B == 32'd0) ? 32'd1 : B;
    prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u     = {32'd0, A} * {32'd0, B};
    // The single signed overflow case is pinned explicitly rather than left
    // to the wrap behaviour of the divide operator.
    if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      quot_s = $signed(A) / $signed(div_b);
      rem_s  = $signed(A) % $signed(div_b);
    end
    case (op)
      OP_MULT:  res_nxt = prod_s;
      OP_MULTU: res_nxt = prod_u;
      OP_DIV: begin
        res_nxt    = {rem_s, quot_s};
        res_wr_nxt = (B != 32'd0);
        cnt_load   = CNT_W'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_nxt    = {A % div_b, A / div_b};
        res_wr_nxt = (B != 32'd0);
        cnt_load   = CNT_W'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  // Control decode: new operations are only honoured while idle.
  always_comb begin
    accept  = 1'b0;
    wr_mthi = 1'b0;
    wr_mtlo = 1'b0;
    commit  = 1'b0;
    if (state == S_IDLE && Start) begin
      accept  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
      wr_mthi = (op == OP_MTHI);
      wr_mtlo = (op == OP_MTLO);
    end
    if (state == S_BUSY && cnt == CNT_W'(1)) begin
      commit = 1'b1;
    end
  end

  // Next-state logic: idle -> busy on accept, busy -> idle when the counter expires.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_BUSY;
      S_BUSY:  if (commit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counter, staging and architectural register updates.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      stage_hi <= 32'd0;
      stage_lo <= 32'd0;
      stage_wr <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from
      // before this edge, independent of statement order.
      state <= state_nxt;
      if (accept) begin
        cnt      <= cnt_load;
        stage_hi <= res_nxt[63:32];
        stage_lo <= res_nxt[31:0];
        stage_wr <= res_wr_nxt;
      end else if (state == S_BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit && stage_wr) begin
        hi_r <= stage_hi;
        lo_r <= stage_lo;
      end
      if (wr_mthi) hi_r <= A;
      if (wr_mtlo) lo_r <= A;
    end
  end

  // Outputs come straight from registers; there is no combinational input path.
  always_comb begin
    Busy = (state == S_BUSY);
    HI   = hi_r;
    LO   = lo_r;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_muldiv_unit;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present one operation for exactly one rising edge; returns at the falling
  // edge after that rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    Op    = OP_NONE;
  endtask

  // Counts falling edges with Busy high; bounded so a stuck Busy still ends.
  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 50) begin
      n++;
      @(negedge Clk);
    end
  endtask

  int n;
  logic [31:0] old_hi, old_lo;

  initial begin
    Rst_n = 1'b0;
    Start = 1'b0;
    Op    = OP_NONE;
    A     = 32'd0;
    B     = 32'd0;
    #12;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // MULT -2 * 3
    issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle(n);
    check("mult_busy", n, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // MULTU same operands
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle(n);
    check("multu_busy", n, 32'd5);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    // DIV -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy", n, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // DIVU 7 / 2
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_busy", n, 32'd10);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    // MTHI: visible right after its edge, no busy
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_lo", LO, 32'd3);

    // DIV by zero: full busy window, HI/LO untouched
    issue(OP_DIV, 32'd99, 32'd0);
    wait_idle(n);
    check("div0_busy", n, 32'd10);
    check("div0_hi", HI, 32'h1234_5678);
    check("div0_lo", LO, 32'd3);

    // Signed overflow case
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'd0);

    // Reserved and none opcodes with Start do nothing
    issue(OP_RSVD, 32'hCAFE_F00D, 32'd1);
    check("rsvd_busy", {31'd0, Busy}, 32'd0);
    check("rsvd_hi", HI, 32'd0);
    check("rsvd_lo", LO, 32'h8000_0000);
    issue(OP_NONE, 32'hCAFE_F00D, 32'd1);
    check("none_busy", {31'd0, Busy}, 32'd0);
    check("none_lo", LO, 32'h8000_0000);

    // Stability during MULT, with an MTLO pulsed mid-busy that must be ignored
    issue(OP_MTHI, 32'hAAAA_5555, 32'd0);
    issue(OP_MTLO, 32'h5555_AAAA, 32'd0);
    old_hi = HI;
    old_lo = LO;
    issue(OP_MULT, 32'h0001_0000, 32'h0001_0000);
    n = 0;
    while (Busy && n < 50) begin
      check("hold_hi", HI, 32'hAAAA_5555);
      check("hold_lo", LO, 32'h5555_AAAA);
      if (n == 2) begin
        Start = 1'b1;
        Op    = OP_MTLO;
        A     = 32'hDEAD_BEEF;
      end else begin
        Start = 1'b0;
        Op    = OP_NONE;
      end
      n++;
      @(negedge Clk);
    end
    Start = 1'b0;
    Op    = OP_NONE;
    check("hold_busy", n, 32'd5);
    check("hold_hi_done", HI, 32'h0000_0001);
    check("hold_lo_done", LO, 32'h0000_0000);

    // Back-to-back: DIVU issued on the first non-busy cycle after a MULT
    issue(OP_MULT, 32'd6, 32'd7);
    wait_idle(n);
    check("b2b_mult_busy", n, 32'd5);
    check("b2b_mult_lo", LO, 32'd42);
    check("b2b_mult_hi", HI, 32'd0);
    Start = 1'b1;
    Op    = OP_DIVU;
    A     = 32'd100;
    B     = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    Op    = OP_NONE;
    check("b2b_accept", {31'd0, Busy}, 32'd1);
    wait_idle(n);
    check("b2b_divu_busy", n, 32'd10);
    check("b2b_divu_lo", LO, 32'd14);
    check("b2b_divu_hi", HI, 32'd2);

    // Asynchronous reset at busy cycle 3 of a DIV
    issue(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    @(negedge Clk);
    @(negedge Clk);
    check("pre_rst_busy", {31'd0, Busy}, 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (15) @(negedge Clk);
    check("post_rst_busy", {31'd0, Busy}, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);

    // The unit still works after reset
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_idle(n);
    check("post_rst_mul_busy", n, 32'd5);
    check("post_rst_mul_lo", LO, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
